// File: rtl/chipset_io_hub_pkg.sv
// Shared types and constants for the chipset I/O hub and its slot decoder.
package chipset_pkg;

  localparam int          IO_ADDR_W  = 10;
  localparam logic [7:0]  IDLE_DATA  = 8'hFF;
  localparam int          MAX_SLOTS  = 8;
  localparam int          SLOT_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY,
    HOLD
  } hub_state_e;

  function automatic logic slot_match(input logic [IO_ADDR_W-1:0] addr,
                                      input logic [IO_ADDR_W-1:0] base,
                                      input logic [IO_ADDR_W-1:0] mask);
    return ((addr & mask) == (base & mask));
  endfunction

endpackage

// File: rtl/chipset_io_hub_if.sv
// CPU-side I/O bus of the hub: address, command strobes, read data and ready.
interface chipset_io_hub_if;
  import chipset_pkg::*;

  logic [IO_ADDR_W-1:0] ADDRESS;
  logic                 X_IO_OR_M;
  logic                 IOR_N;
  logic                 IOW_N;
  logic                 DEN_N;
  logic                 DT_OR_R;
  logic [7:0]           DATA_OUT;
  logic                 RDY;

  modport master (
    output ADDRESS, X_IO_OR_M, IOR_N, IOW_N, DEN_N, DT_OR_R,
    input  DATA_OUT, RDY
  );

  modport slave (
    input  ADDRESS, X_IO_OR_M, IOR_N, IOW_N, DEN_N, DT_OR_R,
    output DATA_OUT, RDY
  );

endinterface

// File: rtl/chipset_io_hub_decoder.sv
// Combinational slot decoder: per-slot masked compare, lowest index wins.
module io_slot_decoder
  import chipset_pkg::*;
#(
  parameter int NUM_SLOTS = 4
) (
  input  logic [IO_ADDR_W-1:0]           addr_i,
  input  logic                           io_sel_i,
  input  logic [NUM_SLOTS*IO_ADDR_W-1:0] base_i,
  input  logic [NUM_SLOTS*IO_ADDR_W-1:0] mask_i,
  output logic                           hit_o,
  output logic [SLOT_IDX_W-1:0]          idx_o,
  output logic [NUM_SLOTS-1:0]           cs_n_o
);

  logic [NUM_SLOTS-1:0] match;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_match
    assign match[gi] = io_sel_i &&
                       slot_match(addr_i,
                                  base_i[gi*IO_ADDR_W +: IO_ADDR_W],
                                  mask_i[gi*IO_ADDR_W +: IO_ADDR_W]);
  end

  // Scan downwards so the lowest matching slot is the last one written.
  always_comb begin
    hit_o = |match;
    idx_o = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (match[i]) begin
        idx_o = SLOT_IDX_W'(i);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_cs
    assign cs_n_o[gi] = !(hit_o && (idx_o == SLOT_IDX_W'(gi)));
  end

endmodule

// File: rtl/chipset_io_hub.sv
// I/O hub: decodes CPU I/O cycles onto slot chip selects and paces RDY with wait states.
// Optional READY timeout is built in when CHIPSET_IO_HUB_TIMEOUT_EN is defined.
module chipset_io_hub
  import chipset_pkg::*;
#(
  parameter int          NUM_SLOTS      = 4,
  parameter int          WAIT_WIDTH     = 3,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           cpu_clock_posedge,
  chipset_io_hub_if.slave                bus,
  input  logic [NUM_SLOTS*IO_ADDR_W-1:0] slot_base,
  input  logic [NUM_SLOTS*IO_ADDR_W-1:0] slot_mask,
  input  logic [NUM_SLOTS*WAIT_WIDTH-1:0] slot_wait,
  input  logic [NUM_SLOTS-1:0]           slot_ready,
  input  logic [NUM_SLOTS*8-1:0]         slot_data,
  output logic [NUM_SLOTS-1:0]           slot_cs_n,
  output logic                           bus_timeout
);

  hub_state_e            state_q, state_d;
  logic [WAIT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SLOT_IDX_W-1:0] winner_q, winner_d;
  logic [7:0]            rd_latch_q, rd_latch_d;
  logic                  is_read_q, is_read_d;

  logic                  hit;
  logic [SLOT_IDX_W-1:0] hit_idx;
  logic [WAIT_WIDTH-1:0] hit_wait;
  logic                  sel_ready;
  logic [7:0]            sel_data;
  logic                  strobe;

`ifdef CHIPSET_IO_HUB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_q, timeout_d;
`endif

  io_slot_decoder #(
    .NUM_SLOTS(NUM_SLOTS)
  ) u_decoder (
    .addr_i  (bus.ADDRESS),
    .io_sel_i(bus.X_IO_OR_M),
    .base_i  (slot_base),
    .mask_i  (slot_mask),
    .hit_o   (hit),
    .idx_o   (hit_idx),
    .cs_n_o  (slot_cs_n)
  );

  assign strobe = !bus.IOR_N || !bus.IOW_N;

  // Wait count follows the live decode; ready/data follow the latched winner.
  always_comb begin
    hit_wait  = '0;
    sel_ready = 1'b0;
    sel_data  = IDLE_DATA;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (hit_idx == SLOT_IDX_W'(i)) begin
        hit_wait = slot_wait[i*WAIT_WIDTH +: WAIT_WIDTH];
      end
      if (winner_q == SLOT_IDX_W'(i)) begin
        sel_ready = slot_ready[i];
        sel_data  = slot_data[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    winner_d   = winner_q;
    rd_latch_d = rd_latch_q;
    is_read_d  = is_read_q;
`ifdef CHIPSET_IO_HUB_TIMEOUT_EN
    tmo_cnt_d  = (state_q == READY) ? tmo_cnt_q : 16'd0;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (strobe && hit) begin
          state_d   = WAIT;
          cnt_d     = hit_wait;
          winner_d  = hit_idx;
          is_read_d = !bus.IOR_N;
        end
      end
      WAIT: begin
        if (!strobe) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = READY;
        end else if (cpu_clock_posedge) begin
          cnt_d = cnt_q - WAIT_WIDTH'(1);
        end
      end
      READY: begin
        if (!strobe) begin
          state_d = IDLE;
        end else if (sel_ready) begin
          state_d = HOLD;
          if (is_read_q) begin
            rd_latch_d = sel_data;
          end
        end
`ifdef CHIPSET_IO_HUB_TIMEOUT_EN
        else if (cpu_clock_posedge) begin
          if (tmo_cnt_q + 16'd1 >= TIMEOUT_CYCLES) begin
            state_d    = HOLD;
            rd_latch_d = IDLE_DATA;
            timeout_d  = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
          end
        end
`endif
      end
      HOLD: begin
        if (!strobe) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      winner_q   <= '0;
      rd_latch_q <= IDLE_DATA;
      is_read_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      winner_q   <= winner_d;
      rd_latch_q <= rd_latch_d;
      is_read_q  <= is_read_d;
    end
  end

`ifdef CHIPSET_IO_HUB_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt_q <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus_timeout = timeout_q;
`else
  assign bus_timeout = 1'b0;

  // The limit only matters when the timeout counter is built in.
  if (TIMEOUT_CYCLES == 16'd0) begin : g_timeout_unused
  end
`endif

  assign bus.RDY      = (state_q == IDLE) || (state_q == HOLD);
  assign bus.DATA_OUT = ((state_q == HOLD) && !bus.DEN_N && !bus.DT_OR_R) ? rd_latch_q : IDLE_DATA;

endmodule
